// File: rtl/pb_io_sequencer.sv
// Shares one kcpsm3 arithmetic program between N_REQ clients: round-robin grant, operand port map, result capture.
// Optional macro PB_TIMEOUT_EN adds a BUSY-cycle watchdog that aborts with resul=0xFF and err=1.
module pb_io_sequencer #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] oper_1,
    input  logic [8*N_REQ-1:0] oper_2,
    output logic [N_REQ-1:0]   done,
    output logic [7:0]         resul,
    output logic               err,
    output logic               busy,
    input  logic [7:0]         port_id,
    output logic [7:0]         in_port,
    input  logic [7:0]         out_port,
    input  logic               write_strobe,
    input  logic               read_strobe
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_ptr;
    logic [1:0]  r_grant;
    logic        r_start;
    logic [7:0]  r_resul;
    logic [7:0]  r_in_port;

    logic [3:0]  w_req4;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic [2:0]  w_idx;
    logic [1:0]  w_pick;
    logic        w_found;
    logic        w_res_wr;
    logic        w_unused;

    // Widen the client buses to the 4-client maximum so a 2-bit index always selects cleanly.
    assign w_req4   = 4'(req);
    assign w_op1    = 32'(oper_1);
    assign w_op2    = 32'(oper_2);
    assign w_res_wr = write_strobe && (port_id == 8'h02);
    assign w_unused = read_strobe;

    always_comb begin
        w_pick  = 2'd0;
        w_found = 1'b0;
        w_idx   = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = 3'(r_ptr) + 3'(i);
            if (w_idx >= 3'(N_REQ)) w_idx = w_idx - 3'(N_REQ);
            if (!w_found && w_req4[w_idx[1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[1:0];
            end
        end
    end

`ifdef PB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            r_grant <= 2'd0;
            r_start <= 1'b0;
            r_resul <= 8'h00;
`ifdef PB_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_start <= 1'b1;
                        r_state <= S_BUSY;
`ifdef PB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    // A result write on the expiry cycle still counts as a normal completion.
                    if (w_res_wr) begin
                        r_resul <= out_port;
                        r_start <= 1'b0;
                        r_state <= S_DONE;
                    end
`ifdef PB_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        r_resul <= 8'hFF;
                        r_start <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
`endif
                end
                S_DONE: begin
                    r_ptr   <= (r_grant == 2'(N_REQ - 1)) ? 2'd0 : r_grant + 2'd1;
                    r_state <= S_IDLE;
`ifdef PB_TIMEOUT_EN
                    r_err   <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Registered read mux gives kcpsm3 its port data one cycle after port_id settles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_port <= 8'h00;
        end else begin
            case (port_id)
                8'h00:   r_in_port <= w_op1[{r_grant, 3'b000} +: 8];
                8'h01:   r_in_port <= w_op2[{r_grant, 3'b000} +: 8];
                8'h02:   r_in_port <= {7'b0, r_start};
                8'h03:   r_in_port <= {6'b0, r_grant};
                default: r_in_port <= 8'h00;
            endcase
        end
    end

    always_comb begin
        done = '0;
        for (int k = 0; k < N_REQ; k++) begin
            done[k] = (r_state == S_DONE) && (r_grant == 2'(k));
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign resul   = r_resul;
    assign in_port = r_in_port;

endmodule

// File: tb/tb_pb_io_sequencer.sv
// Directed bench for pb_io_sequencer; the bench plays the kcpsm3 program on the port bus.
// Define PB_TIMEOUT_EN to exercise the watchdog scenario instead of the indefinite-wait one.
module tb_pb_io_sequencer;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] oper_1;
    logic [15:0] oper_2;
    logic [1:0]  done;
    logic [7:0]  resul;
    logic        err;
    logic        busy;
    logic [7:0]  port_id;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic        write_strobe;
    logic        read_strobe;

    int checks   = 0;
    int failures = 0;

    pb_io_sequencer #(.N_REQ(2), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .req(req), .oper_1(oper_1), .oper_2(oper_2),
        .done(done), .resul(resul), .err(err), .busy(busy),
        .port_id(port_id), .in_port(in_port), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pbRead(input logic [7:0] port, output logic [7:0] data);
        port_id = port;
        tick();
        data = in_port;
    endtask

    task automatic pbWrite(input logic [7:0] port, input logic [7:0] val);
        port_id      = port;
        out_port     = val;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1;
        req   = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (done !== 2'b00) begin failures++; $display("[TB] FAIL reset_done got=%b exp=00", done); end
        checks++; if (resul !== 8'h00) begin failures++; $display("[TB] FAIL reset_resul got=%h exp=00", resul); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
        pbRead(8'h02, d);
        checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL reset_status got=%h exp=00", d); end
    endtask

    task automatic test_single_add();
        logic [7:0] d;
        oper_1 = 16'h0012;
        oper_2 = 16'h0034;
        req    = 2'b01;
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL add_busy got=%b exp=1", busy); end
        pbRead(8'h02, d);
        checks++; if (d !== 8'h01) begin failures++; $display("[TB] FAIL add_start got=%h exp=01", d); end
        pbRead(8'h00, d);
        checks++; if (d !== 8'h12) begin failures++; $display("[TB] FAIL add_opA got=%h exp=12", d); end
        pbRead(8'h01, d);
        checks++; if (d !== 8'h34) begin failures++; $display("[TB] FAIL add_opB got=%h exp=34", d); end
        pbWrite(8'h02, 8'h46);
        checks++; if (done !== 2'b01) begin failures++; $display("[TB] FAIL add_done got=%b exp=01", done); end
        checks++; if (resul !== 8'h46) begin failures++; $display("[TB] FAIL add_resul got=%h exp=46", resul); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL add_err got=%b exp=0", err); end
        req = 2'b00;
        tick();
        checks++; if (done !== 2'b00) begin failures++; $display("[TB] FAIL add_done_width got=%b exp=00", done); end
        checks++; if (resul !== 8'h46) begin failures++; $display("[TB] FAIL add_resul_hold got=%h exp=46", resul); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL add_idle got=%b exp=0", busy); end
    endtask

    task automatic test_round_robin();
        logic [7:0] d;
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        oper_1 = 16'hA1A0;
        oper_2 = 16'hB1B0;
        req    = 2'b11;
        tick();
        pbRead(8'h03, d);
        checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL rr_first got=%h exp=00", d); end
        pbRead(8'h00, d);
        checks++; if (d !== 8'hA0) begin failures++; $display("[TB] FAIL rr_opA0 got=%h exp=A0", d); end
        pbWrite(8'h02, 8'h11);
        checks++; if (done !== 2'b01) begin failures++; $display("[TB] FAIL rr_done0 got=%b exp=01", done); end
        tick();
        tick();
        pbRead(8'h03, d);
        checks++; if (d !== 8'h01) begin failures++; $display("[TB] FAIL rr_second got=%h exp=01", d); end
        pbRead(8'h01, d);
        checks++; if (d !== 8'hB1) begin failures++; $display("[TB] FAIL rr_opB1 got=%h exp=B1", d); end
        pbWrite(8'h02, 8'h22);
        checks++; if (done !== 2'b10) begin failures++; $display("[TB] FAIL rr_done1 got=%b exp=10", done); end
        checks++; if (resul !== 8'h22) begin failures++; $display("[TB] FAIL rr_resul1 got=%h exp=22", resul); end
        tick();
        tick();
        pbRead(8'h03, d);
        checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL rr_wrap got=%h exp=00", d); end
        pbWrite(8'h02, 8'h33);
        req = 2'b00;
        tick();
    endtask

    task automatic test_ignored_writes();
        logic [7:0] d;
        oper_1 = 16'h0005;
        oper_2 = 16'h0002;
        req    = 2'b01;
        tick();
        pbWrite(8'h05, 8'h99);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL ign_busy got=%b exp=1", busy); end
        checks++; if (done !== 2'b00) begin failures++; $display("[TB] FAIL ign_done got=%b exp=00", done); end
        checks++; if (resul !== 8'h33) begin failures++; $display("[TB] FAIL ign_resul got=%h exp=33", resul); end
        pbWrite(8'h02, 8'h07);
        checks++; if (done !== 2'b01) begin failures++; $display("[TB] FAIL ign_done2 got=%b exp=01", done); end
        checks++; if (resul !== 8'h07) begin failures++; $display("[TB] FAIL ign_resul2 got=%h exp=07", resul); end
        req = 2'b00;
        tick();
        pbWrite(8'h02, 8'h55);
        checks++; if (resul !== 8'h07) begin failures++; $display("[TB] FAIL idle_write got=%h exp=07", resul); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got=%b exp=0", busy); end
        pbRead(8'h40, d);
        checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL other_port got=%h exp=00", d); end
    endtask

    task automatic test_reset_busy();
        logic [7:0] d;
        req = 2'b01;
        tick();
        pbWrite(8'h02, 8'h44);
        req = 2'b10;
        tick();
        tick();
        pbRead(8'h03, d);
        checks++; if (d !== 8'h01) begin failures++; $display("[TB] FAIL rb_grant1 got=%h exp=01", d); end
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rb_busy got=%b exp=0", busy); end
        checks++; if (done !== 2'b00) begin failures++; $display("[TB] FAIL rb_done got=%b exp=00", done); end
        checks++; if (resul !== 8'h00) begin failures++; $display("[TB] FAIL rb_resul got=%h exp=00", resul); end
        reset = 1'b0;
        req   = 2'b00;
        tick();
        checks++; if (done !== 2'b00) begin failures++; $display("[TB] FAIL rb_nodone got=%b exp=00", done); end
        pbRead(8'h02, d);
        checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL rb_start got=%h exp=00", d); end
        req = 2'b11;
        tick();
        pbRead(8'h03, d);
        checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL rb_ptr got=%h exp=00", d); end
        pbWrite(8'h02, 8'h01);
        req = 2'b00;
        tick();
    endtask

`ifdef PB_TIMEOUT_EN
    task automatic test_timeout();
        req = 2'b01;
        tick();
        repeat (15) tick();
        checks++; if (done !== 2'b00) begin failures++; $display("[TB] FAIL to_early got=%b exp=00", done); end
        tick();
        checks++; if (done !== 2'b01) begin failures++; $display("[TB] FAIL to_done got=%b exp=01", done); end
        checks++; if (resul !== 8'hFF) begin failures++; $display("[TB] FAIL to_resul got=%h exp=FF", resul); end
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL to_err got=%b exp=1", err); end
        req = 2'b00;
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL to_err_clr got=%b exp=0", err); end
    endtask
`else
    task automatic test_no_timeout();
        req = 2'b01;
        tick();
        repeat (40) tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL nt_busy got=%b exp=1", busy); end
        checks++; if (done !== 2'b00) begin failures++; $display("[TB] FAIL nt_done got=%b exp=00", done); end
        pbWrite(8'h02, 8'h5A);
        checks++; if (done !== 2'b01) begin failures++; $display("[TB] FAIL nt_done2 got=%b exp=01", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL nt_err got=%b exp=0", err); end
        req = 2'b00;
        tick();
    endtask
`endif

    initial begin
        reset        = 1'b1;
        req          = 2'b00;
        oper_1       = 16'h0000;
        oper_2       = 16'h0000;
        port_id      = 8'h00;
        out_port     = 8'h00;
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        test_reset();
        test_single_add();
        test_round_robin();
        test_ignored_writes();
        test_reset_busy();
`ifdef PB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
